mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port among three requesters: instruction fetch (IF read), load/store-unit load (LS read) and execute-stage store (EX write).
- Sequences each transfer through request, wait and response phases.
- Returns one-cycle completion pulses that requesters use as their ready-go condition. The EX stage uses its pulse as its `wvalid` input.
- Sits between the pipeline stages and the memory/DPI bridge.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; mask width is DATA_W/8.
- TIMEOUT, 1023, maximum cycles spent in WAIT before an error is forced; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetch data; valid while if_done=1.
- ls_req  in  1  load request; held until ls_done.
- ls_addr  in  ADDR_W  load address.
- ls_done  out  1  one-cycle completion pulse for load.
- ls_rdata  out  DATA_W  load data; valid while ls_done=1.
- ex_req  in  1  store request; held until ex_done.
- ex_addr  in  ADDR_W  store address.
- ex_wdata  in  DATA_W  store data.
- ex_wmask  in  DATA_W/8  byte strobes.
- ex_done  out  1  one-cycle store-complete pulse (drives EX `wvalid`).
- err  out  1  pulses together with a done when that transfer timed out.
- mem_req  out  1  port request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_wmask  out  DATA_W/8  latched mask; 0 for reads.
- mem_gnt  in  1  port accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- mem_bvalid  in  1  write response.

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset (rst=0, asynchronous) forces IDLE.
- Reset values: every output is 0, the latched address/data/mask are 0 and the watchdog counter is 0.
- IDLE:
  - Arbitrates among the asserted requests. Fixed priority: EX > LS > IF.
  - Latches the winner's address, data and mask, records owner and direction, then goes to REQ.
  - With no request, stays in IDLE.
- REQ:
  - mem_req=1; mem_we/addr/wdata/wmask come from the latched registers and are stable while mem_req=1.
  - mem_gnt=1 moves to WAIT and clears the counter; otherwise stays in REQ. There is no timeout in REQ.
- WAIT:
  - mem_req=0.
  - A read owner completes on mem_rvalid, which registers mem_rdata; a write owner completes on mem_bvalid.
  - On completion, go to RESP.
  - Responses that do not match the current direction are ignored.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT (TIMEOUT≠0) before completion, go to RESP with the error flag set and the read data forced to 0.
- RESP:
  - Exactly one of if_done/ls_done/ex_done is 1 for this single cycle, with rdata and err valid; then return to IDLE.
  - The requester deasserts or changes its request at the following edge, so the next IDLE samples fresh requests.
- Latency: the minimum is 4 cycles from request to done, when gnt arrives in REQ and the response arrives in the first WAIT cycle.
- Request order and handshakes:
  - The arbiter samples requests only in IDLE.
  - Requests that arrive or drop mid-transfer have no effect on the owner.
  - A requester dropping its req before done is a protocol violation; the transfer still completes and the done pulse is still issued.
- Simultaneous events:
  - mem_rvalid and mem_bvalid together in WAIT: only the one matching the direction counts.
  - Timeout and valid in the same cycle: the valid wins, err=0.
- Output rules: if_rdata and ls_rdata are 0 outside their done cycle, and err=0 outside RESP.
- Reset mid-transfer: the state machine aborts with no done pulse, and a late mem response after reset is ignored in IDLE.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. After each grant, the last owner becomes lowest priority, with rotation order EX→LS→IF. The rotation pointer resets to favour EX.
- Undefined: fixed priority EX > LS > IF, as above.

Test Plan:
- Single IF read: if_req=1, addr=0x80000000; gnt in REQ; rvalid with rdata=0x00000413_00000093 on the first WAIT cycle -> if_done one cycle later with that data, 4 cycles total, mem_wmask=0.
- Store: ex_req=1, addr=0x80001008, wdata=0xDEADBEEF, wmask=0xF0; gnt delayed 3 cycles -> mem_req held with stable values; bvalid -> ex_done pulse, err=0.
- Contention: if_req, ls_req and ex_req all asserted together -> service order EX, LS, IF (fixed priority). Under MEM_ARB_RR_EN with EX re-requesting, the order is EX, LS, IF, EX.
- Timeout: TIMEOUT=8, LS read granted, no rvalid -> ls_done=1, err=1, ls_rdata=0 exactly 8 WAIT cycles after entry.
- Reset in WAIT: rst=0 during an IF wait, then mem_rvalid after release -> no if_done, state IDLE, all outputs 0.
- Mismatched response: LS read in WAIT receives mem_bvalid -> ignored; a subsequent rvalid completes the transfer normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among IF read, LS read and EX write with request/wait/response sequencing.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority EX > LS > IF.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic [ADDR_W-1:0]   ls_addr,
    output logic                ls_done,
    output logic [DATA_W-1:0]   ls_rdata,
    input  logic                ex_req,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W/8-1:0] ex_wmask,
    output logic                ex_done,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_bvalid
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {OWN_EX = 2'd0, OWN_LS = 2'd1, OWN_IF = 2'd2} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                grant_vld;
    owner_e              grant_sel;
    logic                done_hit;
    logic                timed_out;

    assign grant_vld = ex_req | ls_req | if_req;

    // Only the response matching the latched direction can finish a transfer.
    assign done_hit  = we_q ? mem_bvalid : mem_rvalid;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_ARB_RR_EN
    owner_e rr_q, rr_d;

    // rr_q names the requester that currently holds top priority.
    always_comb begin
        grant_sel = OWN_EX;
        case (rr_q)
            OWN_LS:  grant_sel = ls_req ? OWN_LS : (if_req ? OWN_IF : OWN_EX);
            OWN_IF:  grant_sel = if_req ? OWN_IF : (ex_req ? OWN_EX : OWN_LS);
            default: grant_sel = ex_req ? OWN_EX : (ls_req ? OWN_LS : OWN_IF);
        endcase
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == S_IDLE && grant_vld) begin
            case (grant_sel)
                OWN_EX:  rr_d = OWN_LS;
                OWN_LS:  rr_d = OWN_IF;
                default: rr_d = OWN_EX;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= OWN_EX;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        grant_sel = ex_req ? OWN_EX : (ls_req ? OWN_LS : OWN_IF);
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d = grant_sel;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_REQ;
                    case (grant_sel)
                        OWN_EX: begin
                            we_d    = 1'b1;
                            addr_d  = ex_addr;
                            wdata_d = ex_wdata;
                            wmask_d = ex_wmask;
                        end
                        OWN_LS: begin
                            we_d    = 1'b0;
                            addr_d  = ls_addr;
                            wdata_d = '0;
                            wmask_d = '0;
                        end
                        default: begin
                            we_d    = 1'b0;
                            addr_d  = if_addr;
                            wdata_d = '0;
                            wmask_d = '0;
                        end
                    endcase
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A valid response in the timeout cycle still wins over the watchdog.
                if (done_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (timed_out) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_EX;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    assign if_done  = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign ls_done  = (state_q == S_RESP) && (owner_q == OWN_LS);
    assign ex_done  = (state_q == S_RESP) && (owner_q == OWN_EX);
    assign if_rdata = if_done ? rdata_q : '0;
    assign ls_rdata = ls_done ? rdata_q : '0;
    assign err      = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized traffic against an arbitration model.
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MW   = DW / 8;
    localparam int TOUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req, ls_req, ex_req;
    logic [AW-1:0] if_addr, ls_addr, ex_addr;
    logic [DW-1:0] ex_wdata;
    logic [MW-1:0] ex_wmask;
    logic          if_done, ls_done, ex_done, err;
    logic [DW-1:0] if_rdata, ls_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic          mem_bvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    // Requester view: index 0 = EX, 1 = LS, 2 = IF.
    logic [2:0]    reqVec = 3'b000;
    logic [AW-1:0] reqAddr [3];
    logic [DW-1:0] exData = '0;
    logic [MW-1:0] exMask = '0;
    int            lastOwner = 2;

    assign ex_req   = reqVec[0];
    assign ls_req   = reqVec[1];
    assign if_req   = reqVec[2];
    assign ex_addr  = reqAddr[0];
    assign ls_addr  = reqAddr[1];
    assign if_addr  = reqAddr[2];
    assign ex_wdata = exData;
    assign ex_wmask = exMask;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ex_req(ex_req), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_wmask(ex_wmask),
        .ex_done(ex_done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_bvalid(mem_bvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner is the first asserted requester found walking cyclically after the previous owner.
    function automatic int pickOwner(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic newRequester(input int k);
        reqVec[k]  = 1'b1;
        reqAddr[k] = {$urandom, $urandom};
        if (k == 0) begin
            exData = {$urandom, $urandom};
            exMask = MW'($urandom);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput(tag, {if_done, ls_done, ex_done, err}, 4'b0000);
        checkOutput({tag, "_if_rdata"}, if_rdata, '0);
        checkOutput({tag, "_ls_rdata"}, ls_rdata, '0);
    endtask

    // Runs one transfer from IDLE through RESP and back to IDLE; respDelay >= TOUT forces a timeout.
    task automatic applyStimulus(input int gntDelay, input int respDelay, input bit junk,
                                 input logic [DW-1:0] rd);
        int   win;
        bit   isWr;
        bit   tmo;
        int   idleWaits;
        win = pickOwner(reqVec, lastOwner);
        if (win < 0) return;
        isWr = (win == 0);
        tmo  = (respDelay >= TOUT);
        idleWaits = tmo ? TOUT : respDelay;

        tick();
        checkOutput("req_phase", {mem_req, mem_we}, {1'b1, isWr});
        checkOutput("req_addr", mem_addr, reqAddr[win]);
        checkOutput("req_mask", mem_wmask, isWr ? exMask : '0);
        if (isWr) checkOutput("req_wdata", mem_wdata, exData);
        for (int i = 0; i < gntDelay; i++) begin
            tick();
            checkOutput("req_hold", {mem_req, mem_we, mem_wmask}, {1'b1, isWr, isWr ? exMask : MW'(0)});
            checkOutput("req_hold_addr", mem_addr, reqAddr[win]);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;

        for (int w = 0; w < idleWaits; w++) begin
            checkOutput("wait_quiet", {mem_req, if_done, ls_done, ex_done, err}, 5'b0);
            if (junk) begin
                mem_rvalid = isWr;
                mem_bvalid = !isWr;
                mem_rdata  = {$urandom, $urandom};
            end
            tick();
            mem_rvalid = 1'b0;
            mem_bvalid = 1'b0;
        end
        if (!tmo) begin
            checkOutput("wait_quiet", {mem_req, if_done, ls_done, ex_done, err}, 5'b0);
            mem_rdata  = rd;
            mem_rvalid = isWr ? junk : 1'b1;
            mem_bvalid = isWr ? 1'b1 : junk;
            tick();
            mem_rvalid = 1'b0;
            mem_bvalid = 1'b0;
        end

        checkOutput("resp_done", {if_done, ls_done, ex_done}, {win == 2, win == 1, win == 0});
        checkOutput("resp_err", err, tmo);
        checkOutput("resp_if_rdata", if_rdata, (win == 2 && !tmo) ? rd : '0);
        checkOutput("resp_ls_rdata", ls_rdata, (win == 1 && !tmo) ? rd : '0);
`ifdef MEM_ARB_RR_EN
        lastOwner = win;
`endif
        reqVec[win] = 1'b0;
        tick();
        checkQuiet("idle_after");
    endtask

    initial begin
        reqAddr[0] = '0;
        reqAddr[1] = '0;
        reqAddr[2] = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        checkQuiet("reset");
        checkOutput("reset_mem", {mem_req, mem_we, mem_wmask}, '0);
        checkOutput("reset_addr", mem_addr, '0);
        checkOutput("reset_wdata", mem_wdata, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // No request keeps the port idle.
        repeat (3) tick();
        checkOutput("idle_noreq", mem_req, 1'b0);

        // Single IF read at minimum latency.
        reqAddr[2] = 64'h0000_0000_8000_0000;
        reqVec     = 3'b100;
        applyStimulus(0, 0, 1'b0, 64'h00000413_00000093);

        // Store with a delayed grant.
        reqAddr[0] = 64'h0000_0000_8000_1008;
        exData     = 64'h0000_0000_DEAD_BEEF;
        exMask     = 8'hF0;
        reqVec     = 3'b001;
        applyStimulus(3, 0, 1'b0, '0);

        // Contention: all three, then EX re-requests after its first grant.
        newRequester(0);
        newRequester(1);
        newRequester(2);
        applyStimulus(0, 1, 1'b0, {$urandom, $urandom});
        newRequester(0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1'b0, {$urandom, $urandom});

        // Watchdog on an LS read with no response.
        reqAddr[1] = {$urandom, $urandom};
        reqVec     = 3'b010;
        applyStimulus(0, 20, 1'b0, {$urandom, $urandom});

        // Mismatched responses are ignored until the matching one arrives.
        newRequester(1);
        applyStimulus(0, 3, 1'b1, {$urandom, $urandom});
        newRequester(0);
        applyStimulus(1, 2, 1'b1, '0);

        // Valid in the same WAIT cycle as the timeout wins.
        newRequester(2);
        applyStimulus(0, TOUT - 1, 1'b0, {$urandom, $urandom});

        // Reset during an IF wait, then a late read response.
        newRequester(2);
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        rst    = 1'b0;
        reqVec = 3'b000;
        #1;
        checkQuiet("rst_wait");
        checkOutput("rst_wait_mem", {mem_req, mem_we, mem_wmask}, '0);
        checkOutput("rst_wait_addr", mem_addr, '0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        lastOwner  = 2;
        mem_rvalid = 1'b1;
        mem_rdata  = {$urandom, $urandom};
        tick();
        mem_rvalid = 1'b0;
        checkQuiet("late_resp");
        checkOutput("late_resp_req", mem_req, 1'b0);
        tick();
        checkQuiet("late_resp2");

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!reqVec[k] && $urandom_range(0, 1) == 1) newRequester(k);
            end
            if (reqVec == 3'b000) newRequester(int'($urandom_range(0, 2)));
            applyStimulus(int'($urandom_range(0, 3)),
                          ($urandom_range(0, 5) == 0) ? 12 : int'($urandom_range(0, 7)),
                          bit'($urandom_range(0, 1)),
                          {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
